// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: default sizes, depth derivation
// and the occupancy-counter update encoding.
package fifo_param_pkg;

  localparam int unsigned FIFO_DEF_DATA_WIDTH = 10;
  localparam int unsigned FIFO_DEF_ADDR_WIDTH = 3;

  // Occupancy counter action for one clock edge
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Number of entries addressed by a pointer of the given width
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_param_mem_dp.sv
// Storage array for fifo_param: DEPTH x DATA_WIDTH, synchronous write port and
// synchronous registered read port. The array itself is never reset; only the
// read register is, so the FIFO output reads 0 after reset.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset (read register only)
//   i_we, i_waddr, i_wdata  write port
//   i_re, i_raddr           read port; o_rdata updates on the edge where i_re=1
//   o_rdata                 registered read data, held when i_re=0
module fifo_param_mem_dp
  import fifo_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: returns the pre-write contents when read and write hit the same entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold almost flags,
// sticky overflow/underflow error and registered read data with a valid strobe.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   push, pop, FIFO_data_in    write request, read request, write data
//   alto, bajo                 almost-full / almost-empty thresholds (static)
//   FIFO_data_out              registered read data, held between pops
//   data_out_valid             one-cycle pulse after an accepted pop
//   count                      occupancy 0..DEPTH
//   full_fifo, empty_fifo      count == DEPTH / count == 0
//   almost_full_fifo           count >= alto
//   almost_empty_fifo          count <= bajo
//   error                      sticky overflow/underflow indication
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic [ADDR_WIDTH:0]   alto,
  input  logic [ADDR_WIDTH:0]   bajo,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  data_out_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full_fifo,
  output logic                  almost_empty_fifo,
  output logic                  error
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_valid;
  logic                  r_error;

  logic    w_full;
  logic    w_empty;
  logic    w_wr_ok;
  logic    w_rd_ok;
  logic    w_overflow;
  logic    w_underflow;
  cnt_op_e w_cnt_op;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push on full is accepted only when a pop frees the slot on the same edge;
  // a pop on empty is never served, even alongside a push (no bypass).
  assign w_wr_ok     = push & (~w_full | pop);
  assign w_rd_ok     = pop & ~w_empty;
  assign w_overflow  = push & w_full & ~pop;
  assign w_underflow = pop & w_empty;

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_wr_ok && !w_rd_ok) begin
      w_cnt_op = CNT_INC;
    end else if (w_rd_ok && !w_wr_ok) begin
      w_cnt_op = CNT_DEC;
    end
  end

  // Pointers, occupancy, valid strobe and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + CW'(1);
        CNT_DEC: r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= w_rd_ok;
      r_error <= r_error | w_overflow | w_underflow;
    end
  end

  fifo_param_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (FIFO_data_in),
    .i_re    (w_rd_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (FIFO_data_out)
  );

  assign data_out_valid    = r_valid;
  assign count             = r_count;
  assign error             = r_error;
  assign full_fifo         = w_full;
  assign empty_fifo        = w_empty;
  assign almost_full_fifo  = (r_count >= alto);
  assign almost_empty_fifo = (r_count <= bajo);

endmodule
